// File: rtl/mem_access_unit_if.sv
// Word-wide req/ack data bus between the memory-stage unit and the memory.
// Latency: none (wires only). Backpressure: the memory stretches an access by withholding bus_ack.
interface mem_access_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one req/ack word-bus access per MEM-stage load or store.
// Latency: bus_req from the cycle after the request; result and stall release one cycle after bus_ack.
// Backpressure: mem_stall freezes the pipeline until DONE; a bus silent for TIMEOUT cycles is aborted.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       Read_data,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic [1:0]        fault_cause,
    mem_access_unit_if.master bus
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            start, finish_ok, fault_d;
    logic [1:0]      cause_d;
    logic            is_access, is_illegal, is_misaligned;
    logic [3:0]      be_d;
    logic [31:0]     wdata_d;

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'h0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'h0, h};
            default: fmt_load = w;
        endcase
    endfunction

    // Access decode; illegal encodings take priority over misalignment in the reported cause.
    always_comb begin
        is_access     = MemRead | MemWrite;
        is_illegal    = (MemRead & MemWrite)
                      | (MemRead & ((funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)))
                      | (MemWrite & (funct3 >= 3'b011));
        is_misaligned = ((funct3[1:0] == 2'b01) & addr[0])
                      | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        be_d    = 4'b1111;
        wdata_d = wdata;
        if (MemWrite) begin
            case (funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr[1:0];
                    wdata_d = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        start     = 1'b0;
        finish_ok = 1'b0;
        fault_d   = 1'b0;
        cause_d   = 2'b00;
        case (state_q)
            IDLE: begin
                if (is_access) begin
                    mem_stall = 1'b1;
                    if (is_illegal | is_misaligned) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                        cause_d = is_illegal ? 2'b11 : 2'b01;
                    end else begin
                        start   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                // An ack on the final counted cycle still completes the access.
                if (bus.bus_ack) begin
                    finish_ok = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            f3_q          <= 3'b000;
            off_q         <= 2'b00;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'b0000;
            bus.bus_wdata <= 32'h0;
            Read_data     <= 32'h0;
            mem_fault     <= 1'b0;
            fault_cause   <= 2'b00;
        end else begin
            state_q   <= state_d;
            mem_fault <= fault_d;
            if (fault_d) begin
                fault_cause <= cause_d;
            end
            if (start) begin
                cnt_q         <= '0;
                f3_q          <= funct3;
                off_q         <= addr[1:0];
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= MemWrite;
                bus.bus_addr  <= {addr[31:2], 2'b00};
                bus.bus_be    <= be_d;
                bus.bus_wdata <= wdata_d;
            end else begin
                if (state_q == BUSY) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                if (state_d != BUSY) begin
                    bus.bus_req <= 1'b0;
                end
            end
            // Faulted loads clear the result; stores leave it untouched.
            if (finish_ok && !bus.bus_we) begin
                Read_data <= fmt_load(f3_q, off_q, bus.bus_rdata);
            end else if (fault_d && ((state_q == IDLE) ? MemRead : !bus.bus_we)) begin
                Read_data <= 32'h0;
            end
        end
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the pipelined RISC-V datapath. It consumes the EX/MEM-registered ALU result (effective address) and the forwarded store data, and runs a req/ack transaction on a word-wide data bus. It produces byte enables and store-lane replication, and returns sign- or zero-extended load data to the write-back mux. While an access is outstanding it stalls the pipeline, and it reports misaligned, illegal or timed-out accesses as faults.

## Interface
- TIMEOUT, 16: cycles `bus_req` may stay high without `bus_ack` before the access is aborted (≥2).
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemRead  in  1  load in MEM stage.
- MemWrite  in  1  store in MEM stage.
- funct3  in  3  access size/sign, RV32I encoding.
- addr  in  32  effective address (ALU_result_MEM).
- wdata  in  32  store data (Read_data2_MEM), value in low bits.
- Read_data  out  32  formatted load data, held until the next load completes.
- mem_stall  out  1  freeze PC and all pipeline registers.
- mem_fault  out  1  one-cycle fault pulse.
- fault_cause  out  2  01 misaligned, 10 timeout, 11 illegal; valid with mem_fault.
- bus_req  out  1  transaction request, registered.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read word, valid with bus_ack.
- bus_ack  in  1  one-cycle completion strobe.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE with neither MemRead nor MemWrite: no action, mem_stall=0.
- IDLE with an access: mem_stall=1 combinationally.
  - Legal access: latch we/addr/be/wdata/funct3, set bus_req=1, go to BUSY.
  - Illegal access: no bus cycle, go to DONE with a fault.
- Illegal access means any of:
  - MemRead and MemWrite both high (cause 11).
  - Load funct3 ∈ {011,110,111} (cause 11).
  - Store funct3 ≥ 011 (cause 11).
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00 (cause 01).
- Byte enables:
  - SB: be = 0001 << addr[1:0], bus_wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, bus_wdata = {2{wdata[15:0]}}.
  - SW: be = 1111, bus_wdata = wdata.
  - Loads drive be=1111.
- BUSY:
  - mem_stall=1; bus outputs stable; timeout counter increments each cycle.
  - bus_ack sampled high: bus_req←0, go to DONE.
    - For loads, Read_data ← formatted bus_rdata.
    - LB/LBU pick byte lane addr[1:0]; LH/LHU pick half lane addr[1]; sign- or zero-extend to 32 bits; LW is pass-through.
  - Counter reaches TIMEOUT-1 without ack: bus_req←0, go to DONE with cause 10; a load sets Read_data←0.
- DONE:
  - mem_stall=0; mem_fault=1 if a fault is pending.
  - Next edge goes to IDLE unconditionally; the pipeline advances on this edge.
- Faulted loads set Read_data←0. Stores never change Read_data.
- bus_ack arriving outside BUSY is ignored.

## Timing
- Reset (async, immediate): state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, Read_data=0, mem_fault=0, fault_cause=00, counter=0.
- Asserting reset while BUSY drops bus_req in the same instant; the access is lost.
- Request seen in cycle N → bus_req high from N+1.
- Ack in cycle N+k → DONE in N+k+1 (mem_stall low, Read_data valid).
- Minimum stall is 2 cycles (k=1).
- Fault path: request in N → DONE in N+1; mem_stall high only in N.
- Timeout: bus_req is high for exactly TIMEOUT cycles, then DONE.
- An ack on the same edge that the timeout is reached wins: the access completes normally, with no fault.
- mem_fault lasts exactly one cycle.
- Back-to-back accesses: DONE → IDLE → next request, so there is a 1-cycle bubble between bus transactions.

## Test plan
- LW at addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF.
  - Expect bus_be=1111, bus_addr=0x100, Read_data=0xDEADBEEF in DONE, mem_stall high for 4 cycles.
- LB at 0x103 with rdata 0x80112233 → Read_data=0xFFFFFF80.
- LBU at 0x103 with the same rdata → Read_data=0x00000080.
- LHU at 0x102 with rdata 0x80112233 → Read_data=0x00008011.
- SB at 0x0A1 with wdata 0x12345678 → bus_we=1, bus_be=0010, bus_wdata=0x78787878.
- SH at 0x0A2 → bus_be=1100, bus_wdata=0x56785678.
- LW at 0x102 → no bus_req; mem_fault=1 with cause 01 in the next cycle; Read_data=0; mem_stall high for 1 cycle.
- Load with bus_ack never asserted (TIMEOUT=16) → bus_req high for 16 cycles, then mem_fault with cause 10, Read_data=0.
  - Repeat with the ack on cycle 16 → no fault.
- Assert reset in the 2nd BUSY cycle → bus_req=0 immediately, all outputs at reset values.
  - After release, a new SW at 0x10 completes normally.
